// File: rtl/booth_mult_arbiter.sv
// Two-requester arbiter in front of one iterative radix-2 Booth multiplier.
// Define MULT_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module booth_mult_arbiter #(
  parameter int NR_BITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_valid,
  input  logic [NR_BITS-1:0]     req0_m,
  input  logic [NR_BITS-1:0]     req0_r,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [NR_BITS-1:0]     req1_m,
  input  logic [NR_BITS-1:0]     req1_r,
  output logic                   req1_ready,
  output logic                   rsp_valid,
  output logic                   rsp_id,
  output logic [2*NR_BITS-1:0]   rsp_prod,
  input  logic                   rsp_ready,
  output logic                   busy
);

  // One guard bit above the 2*NR_BITS+1 Booth register keeps a most-negative M exact.
  localparam int PW = 2*NR_BITS + 2;
  localparam int CW = $clog2(NR_BITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     p_q, p_d;
  logic [PW-1:0]     a_q, a_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              id_q, id_d;

  logic              grant0, grant1;
  logic              idle;
  logic              accept;
  logic              sel;
  logic [NR_BITS-1:0] op_m, op_r;
  logic [PW-1:0]     sum;

`ifdef MULT_ARB_RR_EN
  // last_grant_q = 1 means requester 1 won the most recent handshake.
  logic last_grant_q, last_grant_d;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = last_grant_q;
      grant1 = !last_grant_q;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) begin
      last_grant_d = sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid && !req0_valid;
  end
`endif

  assign idle       = (state_q == IDLE);
  assign req0_ready = idle && rst_n && grant0;
  assign req1_ready = idle && rst_n && grant1;
  assign accept     = req0_ready || req1_ready;
  assign sel        = req1_ready;
  assign op_m       = sel ? req1_m : req0_m;
  assign op_r       = sel ? req1_r : req0_r;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    sum     = p_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          p_d     = {{(NR_BITS+1){1'b0}}, op_r, 1'b0};
          a_d     = {op_m[NR_BITS-1], op_m, {(NR_BITS+1){1'b0}}};
          cnt_d   = CW'(NR_BITS);
          id_d    = sel;
          state_d = RUN;
        end
      end
      RUN: begin
        unique case (p_q[1:0])
          2'b01:   sum = p_q + a_q;
          2'b10:   sum = p_q - a_q;
          default: sum = p_q;
        endcase
        p_d   = {sum[PW-1], sum[PW-1:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_id    = id_q;
  assign rsp_prod  = p_q[2*NR_BITS:1];
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Self-checking bench for booth_mult_arbiter: vector table, scoreboard queue and corner sequences.
module tb_booth_mult_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_m, req0_r, req1_m, req1_r;
  logic       req0_ready, req1_ready;
  logic       rsp_valid, rsp_id, rsp_ready, busy;
  logic [7:0] rsp_prod;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       id;
    logic [7:0] prod;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic       id;
    logic [3:0] m;
    logic [3:0] r;
    logic [7:0] prod;
  } vec_t;
  vec_t tbl[8];

  booth_mult_arbiter #(.NR_BITS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_m     (req0_m),
    .req0_r     (req0_r),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_m     (req1_m),
    .req1_r     (req1_r),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_prod   (rsp_prod),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s act=timeout exp=event", name);
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_rsp");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_prod", 32'(rsp_prod), 32'(e.prod));
      end
    end
  end

  // Starts and ends just after a rising edge; returns right after the accept edge.
  task automatic do_op(input logic id, input logic [3:0] m, input logic [3:0] r,
                       input logic [7:0] prod);
    int n;
    logic rdy;
    if (id) begin req1_valid = 1'b1; req1_m = m; req1_r = r; end
    else    begin req0_valid = 1'b1; req0_m = m; req0_r = r; end
    n = 0;
    @(negedge clk);
    rdy = id ? req1_ready : req0_ready;
    while (!rdy && n < 50) begin
      @(negedge clk);
      rdy = id ? req1_ready : req0_ready;
      n++;
    end
    if (!rdy) fail_now("accept_wait");
    else sb.push_back('{id: id, prod: prod});
    @(posedge clk);
    #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) fail_now("drain_wait");
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, g, n, e;
    int order[4];
    int exp_order[4];
    logic seen;
    logic [3:0] mm, rr;

    tbl[0] = '{id: 1'b1, m: 4'hF, r: 4'h7, prod: 8'hF9};
    tbl[1] = '{id: 1'b1, m: 4'h8, r: 4'h7, prod: 8'hC8};
    tbl[2] = '{id: 1'b1, m: 4'h8, r: 4'h8, prod: 8'h40};
    tbl[3] = '{id: 1'b1, m: 4'h0, r: 4'hB, prod: 8'h00};
    tbl[4] = '{id: 1'b0, m: 4'h7, r: 4'h7, prod: 8'h31};
    tbl[5] = '{id: 1'b0, m: 4'h8, r: 4'h1, prod: 8'hF8};
    tbl[6] = '{id: 1'b0, m: 4'hF, r: 4'hF, prod: 8'h01};
    tbl[7] = '{id: 1'b1, m: 4'h7, r: 4'h8, prod: 8'hC8};

    rst_n = 1'b0;
    req0_valid = 1'b1; req0_m = 4'h3; req0_r = 4'h5;
    req1_valid = 1'b1; req1_m = 4'h2; req1_r = 4'h2;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_prod", 32'(rsp_prod), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single op with latency and ready-pulse checks
    do_op(1'b0, 4'd3, 4'd5, 8'h0F);
    req0_valid = 1'b1;
    #1;
    chk("ready_after_accept", 32'(req0_ready), 32'd0);
    chk("busy_after_accept", 32'(busy), 32'd1);
    req0_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'd4);
    drain();

    foreach (tbl[i]) begin
      do_op(tbl[i].id, tbl[i].m, tbl[i].r, tbl[i].prod);
      drain();
    end

    // Both requesters valid continuously
    pulse_reset();
`ifdef MULT_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    req0_m = 4'd3; req0_r = 4'hE; req0_valid = 1'b1;
    req1_m = 4'hB; req1_r = 4'd4; req1_valid = 1'b1;
    g = 0;
    n = 0;
    while (g < 4 && n < 200) begin
      @(negedge clk);
      n++;
      if (req0_ready || req1_ready) begin
        chk("one_grant", 32'(req0_ready && req1_ready), 32'd0);
        order[g] = req1_ready ? 1 : 0;
        sb.push_back(req1_ready ? '{id: 1'b1, prod: 8'hEC} : '{id: 1'b0, prod: 8'hFA});
        g++;
      end
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("grant_count", 32'(g), 32'd4);
    for (int i = 0; i < 4; i++) chk("grant_order", 32'(order[i]), 32'(exp_order[i]));
    drain();

    // Backpressure
    rsp_ready = 1'b0;
    do_op(1'b0, 4'hD, 4'd5, 8'hF1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!rsp_valid) fail_now("bp_valid_wait");
    req1_valid = 1'b1; req1_m = 4'd1; req1_r = 4'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_prod", 32'(rsp_prod), 32'hF1);
      chk("bp_id", 32'(rsp_id), 32'd0);
      chk("bp_ready", 32'({req0_ready, req1_ready}), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
    end
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_busy", 32'(busy), 32'd0);
    chk("bp_release_valid", 32'(rsp_valid), 32'd0);
    chk("bp_drained", 32'(sb.size()), 32'd0);

    // Reset after two Booth steps
    do_op(1'b1, 4'd5, 4'd3, 8'h0F);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    sb.delete();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(rsp_valid), 32'd0);
    chk("abort_prod", 32'(rsp_prod), 32'd0);
    chk("abort_id", 32'(rsp_id), 32'd0);
    chk("abort_ready", 32'({req0_ready, req1_ready}), 32'd0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("abort_no_rsp", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    do_op(1'b0, 4'h9, 4'd3, 8'hEB);
    drain();

    // Exhaustive sweep over both requesters
    for (int i = 0; i < 256; i++) begin
      mm = i[7:4];
      rr = i[3:0];
      e = int'($signed(mm)) * int'($signed(rr));
      do_op(i[0], mm, rr, e[7:0]);
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
